intc: RTL and testbench
=======================

INTC -- requirements
Module: intc

Interface
REQ-001 The module SHALL have the parameter VECTOR_BASE, default 32'h0000_0100, giving the handler address of source 0.
REQ-002 The module SHALL have the parameter VECTOR_STRIDE, default 32'h0000_0010, giving the byte spacing between consecutive source handler addresses.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port irq_src, input, 4 bits: interrupt source lines; bit 0 connects to the timer_interrupt output of TIM.
REQ-006 The module SHALL have port en_we, input, 1 bit: write strobe for the enable mask.
REQ-007 The module SHALL have port en_wdata, input, 4 bits: new enable mask value.
REQ-008 The module SHALL have port pc_in, input, 32 bits: PC of the instruction the core would execute next.
REQ-009 The module SHALL have port irq_ack, input, 1 bit: the core accepts the presented request.
REQ-010 The module SHALL have port mret, input, 1 bit: the core signals the end of the handler.
REQ-011 The module SHALL have port irq_req, output, 1 bit: the interrupt request to the core.
REQ-012 The module SHALL have port irq_id, output, 2 bits: the index of the requested or in-service source.
REQ-013 The module SHALL have port irq_vector, output, 32 bits: VECTOR_BASE + irq_id*VECTOR_STRIDE, combinational from irq_id.
REQ-014 The module SHALL have port epc, output, 32 bits: the saved return PC.
REQ-015 The module SHALL have port pending, output, 4 bits: the pending register.
REQ-016 The module SHALL have port enable, output, 4 bits: the enable mask register.
REQ-017 The module SHALL have port in_service, output, 1 bit: high while a handler runs.

Function
REQ-018 The module SHALL register irq_src once per cycle and set pending[i] in the cycle after a 0->1 transition is detected on bit i (edge mode).
REQ-019 A rising edge on bit i coinciding with the clear of pending[i] SHALL leave pending[i] set; set wins.
REQ-020 When en_we=1, enable SHALL load en_wdata on the next edge; enable SHALL gate requests only and SHALL NOT gate the setting of pending.
REQ-021 The FSM SHALL have the states IDLE, REQ and SERVICE.
REQ-022 In IDLE, if (pending & enable) is nonzero, the FSM SHALL latch irq_id as the lowest set index (fixed priority, 0 highest) and go to REQ on the next edge.
REQ-023 In REQ, irq_req SHALL be 1 and irq_id SHALL be held stable; a newly pending source of higher priority SHALL NOT preempt it.
REQ-024 In REQ with irq_ack=1, on the same edge, epc SHALL load pc_in, pending[irq_id] SHALL clear, and the FSM SHALL go to SERVICE.
REQ-025 In REQ, if enable[irq_id] is 0 and irq_ack=0, the FSM SHALL return to IDLE with irq_req=0 and pending unchanged.
REQ-026 In SERVICE, in_service SHALL be 1, irq_req SHALL be 0, and no nesting SHALL occur; mret=1 SHALL return the FSM to IDLE on the next edge.
REQ-027 mret in IDLE or REQ, and irq_ack in IDLE or SERVICE, SHALL be ignored.
REQ-028 Back-to-back interrupts SHALL work: after mret, a still-pending enabled source SHALL raise irq_req 2 cycles later (IDLE, then REQ).
REQ-029 Minimum latency from a source rising edge to irq_req=1 SHALL be 3 cycles (sample, pending, REQ).

Reset
REQ-030 When reset=1 at a clock edge, the FSM SHALL go to IDLE and pending, enable, epc, irq_id, irq_req, in_service and the source sample register SHALL all go to 0, overriding all other inputs.
REQ-031 Reset asserted in REQ or SERVICE SHALL abandon the request or handler without further handshake.

Configuration
REQ-032 When the macro INTC_LEVEL_EN is defined, pending SHALL equal the registered irq_src level, the ack SHALL NOT clear pending, and REQ-019 SHALL NOT apply.
REQ-033 When INTC_LEVEL_EN is undefined, sources SHALL be rising-edge latched as in REQ-018 and REQ-019.

Verification
REQ-034 Scenario: enable=4'b0001, irq_src[0] pulse 1 cycle -> irq_req=1 three cycles later, irq_id=0, irq_vector=32'h100; ack with pc_in=32'h44 -> epc=32'h44, pending=0, in_service=1.
REQ-035 Scenario: enable=4'b1111, edges on bits 3 and 1 in the same cycle -> irq_id=1, vector=32'h110; after ack and mret -> irq_id=3, vector=32'h130.
REQ-036 Scenario: enable=0, edge on bit 2 -> pending=4'b0100, irq_req stays 0; then write enable=4'b0100 -> irq_req=1 two cycles later.
REQ-037 Scenario: in REQ for id 0, write enable=0 before ack -> irq_req=0 next cycle, pending[0] still 1.
REQ-038 Scenario: new edge on bit 0 in the same cycle as the ack of id 0 -> pending[0]=1 after the ack; a second request follows mret.
REQ-039 Scenario: reset=1 during SERVICE -> all outputs 0 next cycle; mret afterwards has no effect.

Source files
------------

// File: rtl/intc_if.sv
// Signal bundle between the interrupt controller and the core/peripherals.
interface intc_if;
  logic [3:0]  irq_src;
  logic        en_we;
  logic [3:0]  en_wdata;
  logic [31:0] pc_in;
  logic        irq_ack;
  logic        mret;
  logic        irq_req;
  logic [1:0]  irq_id;
  logic [31:0] irq_vector;
  logic [31:0] epc;
  logic [3:0]  pending;
  logic [3:0]  enable;
  logic        in_service;

  modport slave (
    input  irq_src, en_we, en_wdata, pc_in, irq_ack, mret,
    output irq_req, irq_id, irq_vector, epc, pending, enable, in_service
  );

  modport master (
    output irq_src, en_we, en_wdata, pc_in, irq_ack, mret,
    input  irq_req, irq_id, irq_vector, epc, pending, enable, in_service
  );
endinterface

// File: rtl/intc.sv
// Four-source fixed-priority interrupt controller with a single request/service slot.
// Define INTC_LEVEL_EN for level-sensitive sources; default build latches rising edges.
module intc #(
  parameter logic [31:0] VECTOR_BASE   = 32'h0000_0100,
  parameter logic [31:0] VECTOR_STRIDE = 32'h0000_0010
) (
  input logic   clk,
  input logic   reset,
  intc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  src_q;
  logic [3:0]  pending_q;
  logic [3:0]  enable_q;
  logic [3:0]  req_vec;
  logic [1:0]  id_q, id_d, hi_pri;
  logic [31:0] epc_q, epc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q    <= 4'b0000;
      enable_q <= 4'b0000;
    end else begin
      src_q <= bus.irq_src;
      if (bus.en_we) enable_q <= bus.en_wdata;
    end
  end

`ifdef INTC_LEVEL_EN
  assign pending_q = src_q;
`else
  logic [3:0] prev_q, rise, clr, pending_d;

  // A new edge in the same cycle as the ack clear keeps the bit set.
  assign rise      = src_q & ~prev_q;
  assign clr       = (state_q == REQ && bus.irq_ack) ? (4'b0001 << id_q) : 4'b0000;
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q    <= 4'b0000;
      pending_q <= 4'b0000;
    end else begin
      prev_q    <= src_q;
      pending_q <= pending_d;
    end
  end
`endif

  assign req_vec = pending_q & enable_q;

  always_comb begin
    hi_pri = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_vec[i]) hi_pri = 2'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    epc_d   = epc_q;
    unique case (state_q)
      IDLE: begin
        if (|req_vec) begin
          state_d = REQ;
          id_d    = hi_pri;
        end
      end
      REQ: begin
        if (bus.irq_ack) begin
          state_d = SERVICE;
          epc_d   = bus.pc_in;
        end else if (!enable_q[id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (bus.mret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= 2'd0;
      epc_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      epc_q   <= epc_d;
    end
  end

  assign bus.irq_req    = (state_q == REQ);
  assign bus.in_service = (state_q == SERVICE);
  assign bus.irq_id     = id_q;
  assign bus.irq_vector = VECTOR_BASE + 32'(id_q) * VECTOR_STRIDE;
  assign bus.epc        = epc_q;
  assign bus.pending    = pending_q;
  assign bus.enable     = enable_q;

endmodule

// File: tb/tb_intc.sv
// Scenario bench for intc: expected (id, vector) pairs are queued at stimulus time and popped on irq_req.
module tb_intc;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] vec;
  } exp_t;

  exp_t exp_q[$];

  intc_if bus ();

  intc u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] vec_of(input logic [1:0] id);
    return 32'h0000_0100 + 32'(id) * 32'h0000_0010;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] id);
    exp_t e;
    e.id  = id;
    e.vec = vec_of(id);
    exp_q.push_back(e);
  endtask

  task automatic write_en(input logic [3:0] v);
    bus.en_we    = 1'b1;
    bus.en_wdata = v;
    step();
    bus.en_we    = 1'b0;
  endtask

  task automatic pulse_src(input logic [3:0] v);
    bus.irq_src = v;
    step();
    bus.irq_src = 4'b0000;
  endtask

  task automatic do_ack(input logic [31:0] pc);
    bus.irq_ack = 1'b1;
    bus.pc_in   = pc;
    step();
    bus.irq_ack = 1'b0;
  endtask

  task automatic do_mret();
    bus.mret = 1'b1;
    step();
    bus.mret = 1'b0;
  endtask

  // Waits a bounded number of cycles for irq_req, then checks it against the queue head.
  task automatic wait_req(input int budget, input string tag);
    exp_t e;
    int   n = 0;
    while (bus.irq_req !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (bus.irq_req !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_req_timeout: irq_req=%0b after %0d cycles, want 1", tag, bus.irq_req, n);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_queue: no expected entry for observed request id=%0d", tag, bus.irq_id);
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if (bus.irq_id !== e.id) begin
        n_fail++;
        $display("FAIL %s_id: got %0d want %0d", tag, bus.irq_id, e.id);
      end
      n_checks++;
      if (bus.irq_vector !== e.vec) begin
        n_fail++;
        $display("FAIL %s_vector: got %h want %h", tag, bus.irq_vector, e.vec);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++; if (bus.irq_req !== 1'b0) begin n_fail++; $display("FAIL reset_irq_req: got %0b want 0", bus.irq_req); end
    n_checks++; if (bus.in_service !== 1'b0) begin n_fail++; $display("FAIL reset_in_service: got %0b want 0", bus.in_service); end
    n_checks++; if (bus.pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b want 0000", bus.pending); end
    n_checks++; if (bus.enable !== 4'b0000) begin n_fail++; $display("FAIL reset_enable: got %b want 0000", bus.enable); end
    n_checks++; if (bus.epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h want 0", bus.epc); end
    n_checks++; if (bus.irq_id !== 2'd0) begin n_fail++; $display("FAIL reset_irq_id: got %0d want 0", bus.irq_id); end
    n_checks++; if (bus.irq_vector !== 32'h100) begin n_fail++; $display("FAIL reset_vector: got %h want 100", bus.irq_vector); end
    // ack and mret while idle must do nothing
    bus.irq_ack = 1'b1;
    bus.mret    = 1'b1;
    step();
    bus.irq_ack = 1'b0;
    bus.mret    = 1'b0;
    n_checks++; if (bus.in_service !== 1'b0 || bus.irq_req !== 1'b0) begin n_fail++; $display("FAIL idle_ignore: in_service=%0b irq_req=%0b want 0 0", bus.in_service, bus.irq_req); end
  endtask

  task automatic test_single();
    write_en(4'b0001);
    bus.irq_src = 4'b0001;
    step();
    bus.irq_src = 4'b0000;
    n_checks++; if (bus.irq_req !== 1'b0) begin n_fail++; $display("FAIL single_lat1: irq_req=%0b want 0", bus.irq_req); end
    step();
    n_checks++; if (bus.pending !== 4'b0001 || bus.irq_req !== 1'b0) begin n_fail++; $display("FAIL single_lat2: pending=%b irq_req=%0b want 0001 0", bus.pending, bus.irq_req); end
    push_exp(2'd0);
    step();
    wait_req(0, "single");
    do_ack(32'h44);
    n_checks++; if (bus.epc !== 32'h44) begin n_fail++; $display("FAIL single_epc: got %h want 44", bus.epc); end
    n_checks++; if (bus.pending !== 4'b0000) begin n_fail++; $display("FAIL single_pending: got %b want 0000", bus.pending); end
    n_checks++; if (bus.in_service !== 1'b1 || bus.irq_req !== 1'b0) begin n_fail++; $display("FAIL single_service: in_service=%0b irq_req=%0b want 1 0", bus.in_service, bus.irq_req); end
    do_mret();
    n_checks++; if (bus.in_service !== 1'b0) begin n_fail++; $display("FAIL single_mret: in_service=%0b want 0", bus.in_service); end
  endtask

  task automatic test_priority();
    write_en(4'b1111);
    pulse_src(4'b1010);
    push_exp(2'd1);
    push_exp(2'd3);
    wait_req(5, "prio_first");
    do_ack(32'h200);
    n_checks++; if (bus.pending !== 4'b1000) begin n_fail++; $display("FAIL prio_pending: got %b want 1000", bus.pending); end
    do_mret();
    wait_req(3, "prio_second");
    do_ack(32'h204);
    do_mret();
    n_checks++; if (bus.pending !== 4'b0000) begin n_fail++; $display("FAIL prio_drain: pending=%b want 0000", bus.pending); end
  endtask

  task automatic test_enable_gate();
    write_en(4'b0000);
    pulse_src(4'b0100);
    step();
    step();
    step();
    n_checks++; if (bus.pending !== 4'b0100) begin n_fail++; $display("FAIL gate_pending: got %b want 0100", bus.pending); end
    n_checks++; if (bus.irq_req !== 1'b0) begin n_fail++; $display("FAIL gate_masked: irq_req=%0b want 0", bus.irq_req); end
    push_exp(2'd2);
    write_en(4'b0100);
    n_checks++; if (bus.irq_req !== 1'b0) begin n_fail++; $display("FAIL gate_early: irq_req=%0b want 0", bus.irq_req); end
    step();
    wait_req(0, "gate");
    do_ack(32'h300);
    do_mret();
  endtask

  task automatic test_disable_in_req();
    write_en(4'b0001);
    pulse_src(4'b0001);
    push_exp(2'd0);
    wait_req(5, "dis");
    write_en(4'b0000);
    step();
    n_checks++; if (bus.irq_req !== 1'b0) begin n_fail++; $display("FAIL dis_drop: irq_req=%0b want 0", bus.irq_req); end
    n_checks++; if (bus.pending !== 4'b0001) begin n_fail++; $display("FAIL dis_pending: got %b want 0001", bus.pending); end
    push_exp(2'd0);
    write_en(4'b0001);
    wait_req(4, "dis_again");
    do_ack(32'h400);
    do_mret();
  endtask

  task automatic test_back_to_back();
    pulse_src(4'b0001);
    push_exp(2'd0);
    wait_req(5, "b2b_first");
    bus.irq_src = 4'b0001;
    step();
    bus.irq_src = 4'b0000;
    n_checks++; if (bus.irq_req !== 1'b1) begin n_fail++; $display("FAIL b2b_hold: irq_req=%0b want 1", bus.irq_req); end
    do_ack(32'h500);
    n_checks++; if (bus.pending !== 4'b0001 || bus.in_service !== 1'b1) begin n_fail++; $display("FAIL b2b_setwins: pending=%b in_service=%0b want 0001 1", bus.pending, bus.in_service); end
    push_exp(2'd0);
    do_mret();
    n_checks++; if (bus.irq_req !== 1'b0 || bus.in_service !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: irq_req=%0b in_service=%0b want 0 0", bus.irq_req, bus.in_service); end
    step();
    wait_req(0, "b2b_second");
    do_ack(32'h504);
    do_mret();
  endtask

  task automatic test_reset_in_service();
    write_en(4'b1111);
    pulse_src(4'b0010);
    push_exp(2'd1);
    wait_req(5, "rst");
    do_ack(32'h80);
    n_checks++; if (bus.epc !== 32'h80 || bus.in_service !== 1'b1) begin n_fail++; $display("FAIL rst_pre: epc=%h in_service=%0b want 80 1", bus.epc, bus.in_service); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (bus.irq_req !== 1'b0 || bus.in_service !== 1'b0 || bus.epc !== 32'h0 || bus.irq_id !== 2'd0 ||
        bus.pending !== 4'b0000 || bus.enable !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_outputs: req=%0b svc=%0b epc=%h id=%0d pend=%b en=%b want all 0",
               bus.irq_req, bus.in_service, bus.epc, bus.irq_id, bus.pending, bus.enable);
    end
    do_mret();
    step();
    n_checks++; if (bus.in_service !== 1'b0 || bus.irq_req !== 1'b0) begin n_fail++; $display("FAIL rst_mret: in_service=%0b irq_req=%0b want 0 0", bus.in_service, bus.irq_req); end
  endtask

  initial begin
    reset        = 1'b1;
    bus.irq_src  = 4'b0000;
    bus.en_we    = 1'b0;
    bus.en_wdata = 4'b0000;
    bus.pc_in    = 32'h0;
    bus.irq_ack  = 1'b0;
    bus.mret     = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_enable_gate();
    test_disable_in_req();
    test_back_to_back();
    test_reset_in_service();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d expected requests never observed, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
